// File: rtl/clock_set_pkg.sv
// Shared encodings and default timing for the clock set-mode controller.
// Mode codes are also decoded by the display mux.
package clock_set_pkg;

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_HOUR = 2'd1;
  localparam logic [1:0] MODE_MIN  = 2'd2;
  localparam logic [1:0] MODE_SEC  = 2'd3;

  // Defaults assume a 100 Hz i_tick.
  localparam int DEF_HOLD_TICKS    = 50;
  localparam int DEF_REPEAT_TICKS  = 10;
  localparam int DEF_TIMEOUT_TICKS = 1000;
  localparam int DEF_BLINK_TICKS   = 50;

  typedef enum logic [1:0] {
    ST_RUN  = MODE_RUN,
    ST_HOUR = MODE_HOUR,
    ST_MIN  = MODE_MIN,
    ST_SEC  = MODE_SEC
  } state_t;

  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_RUN:  next_mode = ST_HOUR;
      ST_HOUR: next_mode = ST_MIN;
      ST_MIN:  next_mode = ST_SEC;
      default: next_mode = ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_repeat.sv
// Up-button edge detect plus hold/auto-repeat timer; emits a single
// one-cycle pulse per requested increment.
module clock_set_repeat
  import clock_set_pkg::*;
#(
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_up,
  input  logic i_tick,
  input  logic i_clr,
  input  logic i_wait,
  output logic o_pulse
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  logic          r_up_prev;
  logic          r_rep;
  logic [HW-1:0] r_hold_cnt;
  logic [RW-1:0] r_rep_cnt;

  logic          w_edge, w_quiet, w_hold_hit, w_rep_hit;
  logic [HW-1:0] w_hold_nxt;
  logic [RW-1:0] w_rep_nxt;

  assign w_edge     = i_up & ~r_up_prev;
  assign w_hold_nxt = r_hold_cnt + 1'b1;
  assign w_rep_nxt  = r_rep_cnt + 1'b1;
  assign w_hold_hit = i_tick & ~r_rep & (w_hold_nxt == HW'(HOLD_TICKS));
  assign w_rep_hit  = i_tick &  r_rep & (w_rep_nxt  == RW'(REPEAT_TICKS));
  // Counters idle (and no pulse) while released, cleared or waiting for release.
  assign w_quiet    = i_clr | i_wait | ~i_up;
  assign o_pulse    = ~w_quiet & (w_edge | w_hold_hit | w_rep_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_prev  <= 1'b0;
      r_rep      <= 1'b0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_up_prev <= i_up;
      if (w_quiet) begin
        r_rep      <= 1'b0;
        r_hold_cnt <= '0;
        r_rep_cnt  <= '0;
      end else if (i_tick) begin
        if (!r_rep) begin
          r_hold_cnt <= w_hold_nxt;
          if (w_hold_hit) begin
            r_rep     <= 1'b1;
            r_rep_cnt <= '0;
          end
        end else begin
          r_rep_cnt <= w_rep_hit ? '0 : w_rep_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode FSM for the clock datapath: mode sequencing, increment strobes,
// digit blink and inactivity timeout, all on the i_tick time base.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int BLINK_TICKS   = DEF_BLINK_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  output logic       o_btn_hour,
  output logic       o_btn_min,
  output logic       o_btn_sec,
  output logic [1:0] o_mode,
  output logic       o_blink
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  state_t        r_state;
  logic          r_wait_release;
  logic [TW-1:0] r_tmo_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          r_btn_hour, r_btn_min, r_btn_sec;

  logic w_set, w_tmo_hit, w_trans, w_fire;

  assign w_set     = (r_state != ST_RUN);
  assign w_tmo_hit = w_set & (r_tmo_cnt == TW'(TIMEOUT_TICKS));
  assign w_trans   = i_btn_mode | w_tmo_hit;

  // A transition in the same cycle as an up edge suppresses the strobe.
  clock_set_repeat #(
    .HOLD_TICKS   (HOLD_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) u_repeat (
    .clk     (clk),
    .rst     (rst),
    .i_up    (i_btn_up),
    .i_tick  (i_tick),
    .i_clr   (~w_set | w_trans),
    .i_wait  (r_wait_release),
    .o_pulse (w_fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_wait_release <= 1'b0;
      r_tmo_cnt      <= '0;
      r_blink_cnt    <= '0;
      r_blink        <= 1'b1;
      r_btn_hour     <= 1'b0;
      r_btn_min      <= 1'b0;
      r_btn_sec      <= 1'b0;
    end else begin
      r_btn_hour <= w_fire & (r_state == ST_HOUR);
      r_btn_min  <= w_fire & (r_state == ST_MIN);
      r_btn_sec  <= w_fire & (r_state == ST_SEC);

      if (i_btn_mode)     r_state <= next_mode(r_state);
      else if (w_tmo_hit) r_state <= ST_RUN;

      if (w_trans)        r_wait_release <= 1'b1;
      else if (!i_btn_up) r_wait_release <= 1'b0;

      // Any activity (held button, strobe, mode press) restarts the timeout.
      if (!w_set || w_trans || w_fire || i_btn_up) r_tmo_cnt <= '0;
      else if (i_tick)                             r_tmo_cnt <= r_tmo_cnt + 1'b1;

      if (!w_set || w_trans || w_fire) begin
        r_blink     <= 1'b1;
        r_blink_cnt <= '0;
      end else if (i_tick) begin
        if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
          r_blink     <= ~r_blink;
          r_blink_cnt <= '0;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign o_btn_hour = r_btn_hour;
  assign o_btn_min  = r_btn_min;
  assign o_btn_sec  = r_btn_sec;
  assign o_mode     = r_state;
  assign o_blink    = r_blink;

endmodule
